// File: rtl/imm_field_extract_stage.sv
// RV32I immediate format classifier with a registered 2-entry skid output.
// Define IMM_ILLEGAL_DETECT_EN to enable the registered illegal_insn flag.
module imm_field_extract_stage #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic [2:0]       imm_fmt,
  output logic [IMM_W-1:0] imm_raw,
  output logic             sext_en,
  output logic             illegal_insn
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_e;

  typedef struct packed {
    logic [31:0]      inst;
    logic [XLEN-1:0]  pc;
    logic [2:0]       fmt;
    logic [IMM_W-1:0] imm;
    logic             sext;
`ifdef IMM_ILLEGAL_DETECT_EN
    logic             ill;
`endif
  } ent_t;

  state_e state_q, state_d;
  ent_t   out_q, out_d;
  ent_t   skid_q, skid_d;
  ent_t   dec;

  logic [6:0] op;
  logic is_i, is_s, is_b, is_u, is_j;
  logic acc, xfer;

  assign op   = in_inst[6:0];
  assign is_i = (op == 7'b0010011) | (op == 7'b0000011) |
                (op == 7'b1100111) | (op == 7'b1110011) |
                (op == 7'b0001111);
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_u = (op == 7'b0110111) | (op == 7'b0010111);
  assign is_j = (op == 7'b1101111);

  always_comb begin
    dec      = '0;
    dec.inst = in_inst;
    dec.pc   = in_pc;
    unique case (1'b1)
      is_i: begin
        dec.fmt       = FMT_I;
        dec.imm[11:0] = in_inst[31:20];
        dec.sext      = 1'b1;
      end
      is_s: begin
        dec.fmt       = FMT_S;
        dec.imm[11:0] = {in_inst[31:25], in_inst[11:7]};
        dec.sext      = 1'b1;
      end
      is_b: begin
        dec.fmt       = FMT_B;
        dec.imm[12:0] = {in_inst[31], in_inst[7], in_inst[30:25],
                         in_inst[11:8], 1'b0};
        dec.sext      = 1'b1;
      end
      is_u: begin
        dec.fmt       = FMT_U;
        dec.imm[19:0] = in_inst[31:12];
      end
      is_j: begin
        dec.fmt       = FMT_J;
        dec.imm[20:0] = {in_inst[31], in_inst[19:12], in_inst[20],
                         in_inst[30:21], 1'b0};
        dec.sext      = 1'b1;
      end
      default: ;
    endcase
`ifdef IMM_ILLEGAL_DETECT_EN
    // R-type has no immediate but is still a legal instruction
    dec.ill = (in_inst[1:0] != 2'b11) |
              ((dec.fmt == FMT_NONE) & (op != 7'b0110011));
`endif
  end

  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign acc       = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (acc) begin
            out_d   = dec;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (xfer && acc) begin
            out_d = dec;
          end else if (xfer) begin
            state_d = S_EMPTY;
          end else if (acc) begin
            skid_d  = dec;
            state_d = S_TWO;
          end
        end
        S_TWO: begin
          if (xfer) begin
            out_d   = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign out_inst = out_q.inst;
  assign out_pc   = out_q.pc;
  assign imm_fmt  = out_q.fmt;
  assign imm_raw  = out_q.imm;
  assign sext_en  = out_q.sext;
`ifdef IMM_ILLEGAL_DETECT_EN
  assign illegal_insn = out_q.ill;
`else
  assign illegal_insn = 1'b0;
`endif

endmodule

// File: tb/tb_imm_field_extract_stage.sv
// Random + directed bench for imm_field_extract_stage.
// Queue-based reference model of the skid stage and immediate rules.
module tb_imm_field_extract_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  imm_fmt;
  logic [20:0] imm_raw;
  logic        sext_en;
  logic        illegal_insn;

  imm_field_extract_stage dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_inst(in_inst),
    .in_pc(in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .imm_fmt(imm_fmt),
    .imm_raw(imm_raw),
    .sext_en(sext_en),
    .illegal_insn(illegal_insn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [20:0] imm;
    logic        sext;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] i,
                                   input logic [31:0] p);
    exp_t        e;
    int unsigned w;
    logic [6:0]  o;
    w = i;
    o = i[6:0];
    e.inst = i;
    e.pc   = p;
    e.fmt  = 3'd0;
    e.imm  = '0;
    case (o)
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
        e.fmt = 3'd1;
        e.imm = 21'(w >> 20);
      end
      7'h23: begin
        e.fmt = 3'd2;
        e.imm = 21'(((w >> 25) << 5) | ((w >> 7) & 31));
      end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = 21'((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                    (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1));
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        e.imm = 21'(w >> 12);
      end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = 21'((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                    (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1));
      end
      default: ;
    endcase
    e.sext = (e.fmt == 3'd1) || (e.fmt == 3'd2) ||
             (e.fmt == 3'd3) || (e.fmt == 3'd5);
`ifdef IMM_ILLEGAL_DETECT_EN
    e.ill = (i[1:0] != 2'b11) || (e.fmt == 3'd0 && o != 7'h33);
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      chk("out_inst", out_inst, q[0].inst);
      chk("out_pc", out_pc, q[0].pc);
      chk("imm_fmt", 32'(imm_fmt), 32'(q[0].fmt));
      chk("imm_raw", 32'(imm_raw), 32'(q[0].imm));
      chk("sext_en", 32'(sext_en), 32'(q[0].sext));
      chk("illegal", 32'(illegal_insn), 32'(q[0].ill));
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins,
                      input logic [31:0] p, input logic ordy,
                      input logic fl);
    logic rdy, xf;
    in_valid  = v;
    in_inst   = ins;
    in_pc     = p;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    rdy = (q.size() < 2);
    xf  = (q.size() != 0) && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (xf) void'(q.pop_front());
      if (v && rdy) q.push_back(ref_dec(ins, p));
    end
    #1;
    check_all();
  endtask

  task automatic do_reset_mid();
    step(1'b1, 32'h00100093, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 32'h104, 1'b0, 1'b0);
    in_valid = 1'b0;
    flush    = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_ready", 32'(in_ready), 32'd1);
    chk("rst_async_inst", out_inst, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_rel_valid", 32'(out_valid), 32'd0);
  endtask

  logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                           7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  initial begin
    logic [31:0] r, ins;
    int          pick;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_imm", 32'(imm_raw), 32'd0);
    chk("rst_fmt", 32'(imm_fmt), 32'd0);
    chk("rst_sext", 32'(sext_en), 32'd0);
    chk("rst_ill", 32'(illegal_insn), 32'd0);
    #4;
    reset = 1'b0;

    step(1'b1, 32'hFFF00093, 32'h0, 1'b1, 1'b0);
    chk("addi_fmt", 32'(imm_fmt), 32'd1);
    chk("addi_imm", 32'(imm_raw), 32'h00FFF);
    chk("addi_sext", 32'(sext_en), 32'd1);
    step(1'b1, 32'hFE112E23, 32'h4, 1'b1, 1'b0);
    chk("sw_fmt", 32'(imm_fmt), 32'd2);
    chk("sw_imm", 32'(imm_raw), 32'h00FFC);
    step(1'b1, 32'h00000463, 32'h8, 1'b1, 1'b0);
    chk("beq_fmt", 32'(imm_fmt), 32'd3);
    chk("beq_imm", 32'(imm_raw), 32'h00008);
    step(1'b1, 32'h123452B7, 32'hC, 1'b1, 1'b0);
    chk("lui_fmt", 32'(imm_fmt), 32'd4);
    chk("lui_imm", 32'(imm_raw), 32'h12345);
    chk("lui_sext", 32'(sext_en), 32'd0);
    step(1'b1, 32'h00000000, 32'h10, 1'b1, 1'b0);
    chk("zero_fmt", 32'(imm_fmt), 32'd0);
`ifdef IMM_ILLEGAL_DETECT_EN
    chk("zero_ill", 32'(illegal_insn), 32'd1);
`else
    chk("zero_ill", 32'(illegal_insn), 32'd0);
`endif
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'hAAA00013, 32'hA0, 1'b0, 1'b0);
    step(1'b1, 32'hBBB00013, 32'hB0, 1'b0, 1'b0);
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_head", out_inst, 32'hAAA00013);
    step(1'b1, 32'hCCC00013, 32'hC0, 1'b0, 1'b0);
    chk("bp_hold", out_inst, 32'hAAA00013);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_second", out_inst, 32'hBBB00013);
    chk("bp_second_v", 32'(out_valid), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_drained", 32'(out_valid), 32'd0);

    step(1'b1, 32'h11100013, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h22200013, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'h33300013, 32'h208, 1'b0, 1'b1);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("fl_nodrop", 32'(out_valid), 32'd0);

    do_reset_mid();

    for (int k = 0; k < 400; k++) begin
      r    = $urandom();
      pick = $urandom_range(0, 11);
      if (pick < 10) ins = {r[31:7], ops[pick]};
      else ins = r;
      step($urandom_range(0, 3) != 0, ins, $urandom(),
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      if (k == 200) do_reset_mid();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
